// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: round-robin arbiter sharing one dual_ram port between NREQ requesters
module dual_ram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic               rvalid,
    output logic [IDW-1:0]     rid,
    output logic [DW-1:0]      rdata,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);
    logic [IDW-1:0] ptr_q, ptr_d, gsel, cand;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic           rd_pend_q, rd_pend_d;
    logic [IDW-1:0] rd_id_q, rd_id_d;
    logic           rvalid_q, rvalid_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           acc;

    // grant the first requester at or after ptr; scanning from the far end lets the nearest one win
    always_comb begin
        gnt  = '0;
        gsel = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gsel      = cand;
            end
        end
        if (!rst) gnt = '0;
    end

    assign acc = |gnt;

    // issue the accepted request to the RAM, advance the pointer and pipeline the read return
    always_comb begin
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_pend_d   = 1'b0;
        rd_id_d     = rd_id_q;
        rvalid_d    = rd_pend_q;
        rid_d       = rd_id_q;
        if (acc) begin
            mem_we_d    = wr[gsel];
            mem_addr_d  = addr[int'(gsel)*AW +: AW];
            mem_wdata_d = wdata[int'(gsel)*DW +: DW];
            rd_pend_d   = ~wr[gsel];
            rd_id_d     = gsel;
            ptr_d       = lock[gsel] ? gsel : (int'(gsel) == NREQ - 1 ? '0 : gsel + IDW'(1));
        end
    end

    // state registers; reset drops any pending read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= '0;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rdata     = mem_rdata;
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb_dual_ram_arbiter: directed scoreboard bench for dual_ram_arbiter with a 32x16 RAM model
module tb_dual_ram_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] d;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, wr = '0, lock = '0;
    logic [19:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [1:0]  rid;
    logic [15:0] rdata;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [32];

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];
    rsp_t e;
    int   seq_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int   seq_b[4] = '{3, 1, 3, 1};
    int   seq_c[4] = '{1, 2, 1, 2};

    dual_ram_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .lock(lock), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous RAM port: write when we, registered read otherwise
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set(input int i, input logic w, input logic [4:0] a, input logic [15:0] d);
        wr[i] = w;
        addr[i*5 +: 5] = a;
        wdata[i*16 +: 16] = d;
    endtask

    // monitor: every read return must match the oldest expected response
    always @(negedge clk) begin
        if (rst && rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rid=%0d rdata=%0h expected no return", rid, rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rid", 32'(rid), 32'(e.id));
                chk("rdata", 32'(rdata), 32'(e.d));
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            req = 4'hF;
            #1;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_we", 32'(mem_we), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
        end
        rst = 1'b1;
        #1;
        chk("first_gnt", 32'(gnt), 1);
        req = 4'h0;
        @(negedge clk);
        set(0, 1'b1, 5'd3, 16'hA5A5);
        req = 4'b0001;
        #1;
        chk("wr_gnt", 32'(gnt), 1);
        @(negedge clk);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 3);
        chk("wr_data", 32'(mem_wdata), 32'hA5A5);
        set(0, 1'b0, 5'd3, 16'h0);
        #1;
        chk("rd_gnt", 32'(gnt), 1);
        exp_q.push_back(rsp_t'({2'd0, 16'hA5A5}));
        @(negedge clk);
        chk("we_one_cycle", 32'(mem_we), 0);
        chk("rd_lat1", 32'(rvalid), 0);
        req = 4'h0;
        @(negedge clk);
        chk("rd_lat2", 32'(rvalid), 1);
        @(negedge clk);
        chk("rd_done", 32'(rvalid), 0);
        set(3, 1'b1, 5'd31, 16'h0);
        req = 4'b1000;
        #1;
        chk("wrap_gnt", 32'(gnt), 8);
        @(negedge clk);
        for (int i = 0; i < 4; i++) set(i, 1'b1, 5'(16 + i), 16'(i));
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_all", 32'(gnt), 32'(1) << seq_a[k]);
            @(negedge clk);
        end
        req = 4'b0010;
        #1;
        chk("rr_ptr2", 32'(gnt), 2);
        @(negedge clk);
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_1010", 32'(gnt), 32'(1) << seq_b[k]);
            @(negedge clk);
        end
        req = 4'b0001;
        #1;
        chk("rr_ptr1", 32'(gnt), 1);
        @(negedge clk);
        req = 4'b0110;
        lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lock_hold", 32'(gnt), 2);
            @(negedge clk);
        end
        lock = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lock_drop", 32'(gnt), 32'(1) << seq_c[k]);
            @(negedge clk);
        end
        req = 4'b1000;
        for (int a = 0; a < 4; a++) begin
            set(3, 1'b1, 5'(a), 16'(16'h0010 + a));
            #1;
            chk("fill_gnt", 32'(gnt), 8);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) set(i, 1'b0, 5'(i), 16'h0);
        req = 4'hF;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                if (c > 0) req[c-1] = 1'b0;
                #1;
                chk("pipe_gnt", 32'(gnt), 32'(1) << c);
                exp_q.push_back(rsp_t'({2'(c), 16'(16'h0010 + c)}));
            end else begin
                req = 4'h0;
                #1;
            end
            chk("pipe_rvalid", 32'(rvalid), 32'((c >= 2 && c <= 5) ? 1 : 0));
            @(negedge clk);
        end
        set(2, 1'b0, 5'd5, 16'h0);
        req = 4'b0100;
        #1;
        chk("mr_gnt", 32'(gnt), 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'hF;
        wr = 4'hF;
        #1;
        chk("mr_rvalid_now", 32'(rvalid), 0);
        chk("mr_gnt_rst", 32'(gnt), 0);
        @(negedge clk);
        chk("mr_rvalid_e1", 32'(rvalid), 0);
        chk("mr_we", 32'(mem_we), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_ptr0", 32'(gnt), 1);
        req = 4'h0;
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_rvalid", 32'(rvalid), 0);
        end
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dual_ram_arbiter.md
# dual_ram_arbiter

Round-robin arbiter that shares one port of the 32x16 `dual_ram` between NREQ requesters. Each requester presents a single read or write request with a req/gnt handshake. The arbiter drives the RAM port with registered signals and returns read data tagged with the requester ID. One instance sits in front of each RAM port (`w_*` side or `r_*` side).

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 5: RAM address width.
- DW, 16: RAM data width.
- IDW, 2: requester ID width, equal to clog2(NREQ).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request.
- wr  in  NREQ  per-requester direction: 1 = write, 0 = read.
- lock  in  NREQ  per-requester priority hold.
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- gnt  out  NREQ  one-hot grant (combinational); a transfer occurs on an edge where req[i]&gnt[i].
- rvalid  out  1  read data valid.
- rid  out  IDW  requester ID owning rdata.
- rdata  out  DW  read data, a wire copy of mem_rdata.
- mem_we  out  1  RAM port write enable (the `we`/`re` input of `dual_ram`).
- mem_addr  out  AW  RAM port address.
- mem_wdata  out  DW  RAM port write data.
- mem_rdata  in  DW  RAM port data out (the `w_dout`/`r_dout` output of `dual_ram`).

## Operation
- State:
  - ptr (IDW bits): round-robin start point.
  - Issue registers: mem_we, mem_addr, mem_wdata, plus an internal rd_pend flag and rd_id.
  - Return registers: rvalid, rid.
- Grant:
  - gnt[i]=1 for the first i with req[i]=1, searching ptr, ptr+1, … with wrap modulo NREQ.
  - At most one bit of gnt is set. gnt=0 when req=0. gnt is forced to 0 while rst=0.
- Accept (edge with some gnt[i]=1):
  - mem_we ← wr[i]; mem_addr ← addr[i]; mem_wdata ← wdata[i].
  - rd_pend ← ~wr[i]; rd_id ← i.
- No accept: mem_we ← 0; rd_pend ← 0; mem_addr and mem_wdata hold their values. The RAM performs a harmless read.
- Pointer update on accept:
  - lock[i]=0: ptr ← (i+1) mod NREQ.
  - lock[i]=1: ptr ← i, so requester i keeps top priority while it keeps requesting.
  - lock on a requester that is not granted has no effect.
  - No accept: ptr holds.
- Read return:
  - rvalid ← rd_pend and rid ← rd_id every edge.
  - rdata = mem_rdata, valid only while rvalid=1.
- Requesters hold req, wr, addr and wdata stable until they see the accepting edge. After that edge they may change them or present a new request.
- Ordering: accepts reach the RAM in accept order. A read accepted on the edge after a write to the same address returns the new data.

## Timing
- Reset (rst=0, asynchronous): ptr=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_pend=0, rd_id=0, rvalid=0, rid=0, gnt=0.
- A reset asserted mid-read drops the pending return: rvalid=0 immediately and no stale rvalid after release.
- First accept possible on the first rising edge after rst rises.
- Accept edge E0 → RAM port signals valid in cycle E0..E1 → RAM samples at E1.
- Read: rvalid=1 in cycle E1..E2, with rdata holding mem[addr]. Latency is 2 edges.
- Write: the RAM is updated at E1. No response is returned.
- Throughput: one accept per cycle. Back-to-back reads produce rvalid high on consecutive cycles, each with its own rid.
- Fairness: with all NREQ requesting continuously and lock=0, each requester is granted exactly once every NREQ cycles.
- Simultaneous events:
  - A new accept and a read return on the same edge are independent.
  - ptr wrap: i=NREQ-1 with lock=0 gives ptr ← 0.

## Test plan
- Reset/idle: hold rst=0 with req=4'b1111. Check gnt=0, mem_we=0, rvalid=0. Release rst, then check that req[0] is granted first (ptr=0).
- Write-then-read: req0 writes 16'hA5A5 to addr 3, then reads addr 3. Check mem_we=1 for one cycle, then rvalid=1 two edges after the read accept with rdata=16'hA5A5 and rid=0.
- Round-robin: req=4'b1111 held for 8 cycles with lock=0. Check the grant sequence 0,1,2,3,0,1,2,3. Then req=4'b1010 with ptr=2: check the grant sequence 3,1,3,1.
- Lock: req1 and req2 both high, lock[1]=1. Check that 1 is granted every cycle. Drop lock[1] and check the sequence becomes 1, 2, 1, 2.
- Pipelined reads: after filling addr 0..3 with 16'h0010..16'h0013, requesters 0..3 read addr 0..3 back-to-back. Check rvalid high for 4 consecutive cycles with (rid, rdata) = (0,0010), (1,0011), (2,0012), (3,0013).
- Reset mid-read: assert rst=0 on the cycle right after a read accept. Check rvalid=0 immediately, no rvalid pulse after release, and ptr=0.
